// File: rtl/collatz_engine.sv
// collatz_engine: iterates a seed through the Collatz map (n/2 or 3n+1)
// until it reaches 1, an overflow, or a programmable step limit. The engine
// reports the orbit length, the largest value reached and a termination code.
// An optional shortcut mode folds (3n+1)/2 into a single cycle.
module collatz_engine #(
  parameter int WIDTH     = 144,
  parameter int OLEN_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     seed,
  input  logic                 shortcut,
  input  logic [OLEN_BITS-1:0] max_steps,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic [OLEN_BITS-1:0] orbit_len,
  output logic [WIDTH-1:0]     path_record
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_OVF   = 2'd1,
    ST_LIMIT = 2'd2,
    ST_ZERO  = 2'd3
  } status_t;

  state_t                 state;
  logic [WIDTH-1:0]       iter;
  logic                   shortcut_q;
  logic [OLEN_BITS-1:0]   limit_q;

  // Datapath terms derived from the current iterate.
  logic [WIDTH+1:0]       triple;     // 3n+1, wide enough never to wrap
  logic                   is_odd;
  logic                   is_zero;
  logic                   is_one;
  logic                   overflow;
  logic [OLEN_BITS:0]     inc;
  logic [OLEN_BITS:0]     len_next;   // one extra bit so the limit compare cannot wrap
  logic                   limit_hit;
  logic [WIDTH-1:0]       iter_next;
  logic [WIDTH-1:0]       record_next;

  // Evaluate the next step and every termination condition for this cycle.
  always_comb begin
    triple      = ({2'b00, iter} << 1) + {2'b00, iter} + {{(WIDTH+1){1'b0}}, 1'b1};
    is_odd      = iter[0];
    is_zero     = (iter == '0);
    is_one      = (iter == {{(WIDTH-1){1'b0}}, 1'b1});
    overflow    = |triple[WIDTH+1:WIDTH];
    inc         = (is_odd && shortcut_q) ? (OLEN_BITS+1)'(2) : (OLEN_BITS+1)'(1);
    len_next    = {1'b0, orbit_len} + inc;
    limit_hit   = (len_next > {1'b0, limit_q});
    // Defaults describe the even step; odd steps override below.
    iter_next   = iter >> 1;
    record_next = path_record;
    if (is_odd) begin
      iter_next = shortcut_q ? triple[WIDTH:1] : triple[WIDTH-1:0];
      // The record tracks 3n+1 even when shortcut mode never stores it.
      if (triple[WIDTH-1:0] > path_record) begin
        record_next = triple[WIDTH-1:0];
      end
    end
  end

  // Control FSM and result registers; every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= ST_OK;
      orbit_len   <= '0;
      path_record <= '0;
      iter        <= '0;
      shortcut_q  <= 1'b0;
      limit_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every term above sees
      // this cycle's register values regardless of statement order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            status      <= ST_OK;
            iter        <= seed;
            orbit_len   <= '0;
            path_record <= seed;
            shortcut_q  <= shortcut;
            limit_q     <= (max_steps == '0) ? '1 : max_steps;
          end
        end
        RUN: begin
          if (is_zero || is_one || limit_hit || (is_odd && overflow)) begin
            // A failing iterate is never committed; the counters keep the
            // last valid values.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (is_zero)        status <= ST_ZERO;
            else if (is_one)    status <= ST_OK;
            else if (limit_hit) status <= ST_LIMIT;
            else                status <= ST_OVF;
          end else begin
            iter        <= iter_next;
            orbit_len   <= len_next[OLEN_BITS-1:0];
            path_record <= record_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_engine.sv
// Self-checking bench for collatz_engine: a directed vector table with
// known orbits, hand-written sequences for back-to-back starts and reset
// mid-run, and randomized runs checked against a plain-arithmetic model.
// A second instance with WIDTH=8 exercises the overflow path.
module tb_collatz_engine;

  localparam int W  = 144;
  localparam int W8 = 8;
  localparam int OB = 16;

  logic clk = 1'b0;
  logic reset;

  // Wide instance
  logic          start_a;
  logic [W-1:0]  seed_a;
  logic          sc_a;
  logic [OB-1:0] ms_a;
  logic          busy_a, done_a;
  logic [1:0]    status_a;
  logic [OB-1:0] len_a;
  logic [W-1:0]  rec_a;

  // Narrow instance
  logic          start_b;
  logic [W8-1:0] seed_b;
  logic          sc_b;
  logic [OB-1:0] ms_b;
  logic          busy_b, done_b;
  logic [1:0]    status_b;
  logic [OB-1:0] len_b;
  logic [W8-1:0] rec_b;

  int vectors     = 0;
  int miscompares = 0;

  // Selects which instance the shared run task observes.
  bit            sel8 = 1'b0;
  logic          cur_busy, cur_done;
  logic [1:0]    cur_status;
  logic [OB-1:0] cur_len;
  logic [W-1:0]  cur_rec;

  assign cur_busy   = sel8 ? busy_b   : busy_a;
  assign cur_done   = sel8 ? done_b   : done_a;
  assign cur_status = sel8 ? status_b : status_a;
  assign cur_len    = sel8 ? len_b    : len_a;
  assign cur_rec    = sel8 ? {{(W-W8){1'b0}}, rec_b} : rec_a;

  collatz_engine #(.WIDTH(W), .OLEN_BITS(OB)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start_a),
    .seed       (seed_a),
    .shortcut   (sc_a),
    .max_steps  (ms_a),
    .busy       (busy_a),
    .done       (done_a),
    .status     (status_a),
    .orbit_len  (len_a),
    .path_record(rec_a)
  );

  collatz_engine #(.WIDTH(W8), .OLEN_BITS(OB)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .seed       (seed_b),
    .shortcut   (sc_b),
    .max_steps  (ms_b),
    .busy       (busy_b),
    .done       (done_b),
    .status     (status_b),
    .orbit_len  (len_b),
    .path_record(rec_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [147:0] act, input logic [147:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the orbit with plain arithmetic. cyc is the edge at
  // which the engine should report done (committed steps + 1).
  task automatic ref_run(input logic [147:0] s, input bit sc, input int ms, input int w,
                         output int st, output int olen, output logic [147:0] rec,
                         output int cyc);
    logic [147:0] n, t, top;
    int lim, inc;
    bit fin;
    top  = 148'd1 << w;
    lim  = (ms == 0) ? 65535 : ms;
    n    = s;
    olen = 0;
    rec  = s;
    cyc  = 0;
    st   = 0;
    fin  = 1'b0;
    while (!fin && cyc < 100000) begin
      cyc++;
      if (n == 0) begin
        st = 3; fin = 1'b1;
      end else if (n == 1) begin
        st = 0; fin = 1'b1;
      end else begin
        inc = (n[0] && sc) ? 2 : 1;
        if (olen + inc > lim) begin
          st = 2; fin = 1'b1;
        end else if (n[0]) begin
          t = n * 3 + 1;
          if (t >= top) begin
            st = 1; fin = 1'b1;
          end else begin
            if (t > rec) rec = t;
            n    = sc ? (t >> 1) : t;
            olen = olen + inc;
          end
        end else begin
          n    = n >> 1;
          olen = olen + 1;
        end
      end
    end
  endtask

  // Launch one run from the current negedge and check its results. Returns
  // at the negedge where done is seen, so a chained call can restart there.
  task automatic run(input bit b8, input logic [W-1:0] s, input bit sc, input logic [OB-1:0] ms,
                     input int e_st, input int e_len, input logic [W-1:0] e_rec, input int e_cyc,
                     input bit chain, input string name);
    int k, busy_cnt;
    sel8 = b8;
    if (b8) begin
      start_b = 1'b1; seed_b = s[W8-1:0]; sc_b = sc; ms_b = ms;
    end else begin
      start_a = 1'b1; seed_a = s; sc_a = sc; ms_a = ms;
    end
    @(negedge clk);
    // Scramble the inputs mid-run; the latched copies must be used.
    start_a = 1'b0; start_b = 1'b0;
    seed_a  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    seed_b  = 8'($urandom);
    sc_a    = ~sc; sc_b = ~sc;
    ms_a    = 16'($urandom_range(1, 5)); ms_b = ms_a;
    k = 0;
    busy_cnt = 0;
    while (!cur_done && k < e_cyc + 10) begin
      if (cur_busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    check({name, ".done_seen"}, 148'(cur_done), 148'd1);
    check({name, ".done_edge"}, 148'(k), 148'(e_cyc));
    check({name, ".busy_cycles"}, 148'(busy_cnt), 148'(e_cyc));
    check({name, ".busy_at_done"}, 148'(cur_busy), 148'd0);
    check({name, ".status"}, 148'(cur_status), 148'(e_st));
    check({name, ".orbit_len"}, 148'(cur_len), 148'(e_len));
    check({name, ".path_record"}, 148'(cur_rec), 148'(e_rec));
    if (!chain) begin
      @(negedge clk);
      check({name, ".done_pulse_width"}, 148'(cur_done), 148'd0);
      check({name, ".status_hold"}, 148'(cur_status), 148'(e_st));
    end
  endtask

  task automatic run_model(input bit b8, input logic [W-1:0] s, input bit sc, input logic [OB-1:0] ms,
                           input string name);
    int st, olen, cyc;
    logic [147:0] rec;
    ref_run({4'b0, s}, sc, int'(ms), b8 ? W8 : W, st, olen, rec, cyc);
    run(b8, s, sc, ms, st, olen, rec[W-1:0], cyc, 1'b0, name);
  endtask

  typedef struct {
    bit            b8;
    logic [W-1:0]  seed;
    bit            sc;
    logic [OB-1:0] ms;
    int            st;
    int            len;
    logic [W-1:0]  rec;
    int            cyc;
    bit            chain;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [W-1:0] s;
    logic [W-1:0] mask;
    int bits, k, done_cnt;

    reset   = 1'b1;
    start_a = 1'b0; seed_a = '0; sc_a = 1'b0; ms_a = '0;
    start_b = 1'b0; seed_b = '0; sc_b = 1'b0; ms_b = '0;

    // Directed table: {instance, seed, shortcut, max_steps, status, len, record, done edge, chain}
    tbl[0] = '{1'b0, W'(27),  1'b0, 16'd0,  0, 111, W'(9232), 112, 1'b0};
    tbl[1] = '{1'b0, W'(27),  1'b1, 16'd0,  0, 111, W'(9232), 71,  1'b0};
    tbl[2] = '{1'b0, W'(6),   1'b0, 16'd0,  0, 8,   W'(16),   9,   1'b1};
    tbl[3] = '{1'b0, W'(1),   1'b0, 16'd0,  0, 0,   W'(1),    1,   1'b1};
    tbl[4] = '{1'b0, W'(0),   1'b0, 16'd0,  3, 0,   W'(0),    1,   1'b0};
    tbl[5] = '{1'b1, W'(255), 1'b0, 16'd0,  1, 0,   W'(255),  1,   1'b0};
    tbl[6] = '{1'b0, W'(27),  1'b0, 16'd50, 2, 50,  W'(1780), 51,  1'b0};

    repeat (3) @(negedge clk);
    check("reset.busy",      148'(busy_a),   148'd0);
    check("reset.done",      148'(done_a),   148'd0);
    check("reset.status",    148'(status_a), 148'd0);
    check("reset.orbit_len", 148'(len_a),    148'd0);
    check("reset.record",    148'(rec_a),    148'd0);
    check("reset.busy8",     148'(busy_b),   148'd0);
    reset = 1'b0;
    @(negedge clk);

    // Entries 2..4 run back-to-back: each start is raised in its predecessor's done cycle.
    for (int i = 0; i < 7; i++) begin
      run(tbl[i].b8, tbl[i].seed, tbl[i].sc, tbl[i].ms, tbl[i].st, tbl[i].len,
          tbl[i].rec, tbl[i].cyc, tbl[i].chain, $sformatf("vec%0d", i));
    end

    // Overflow mid-orbit on the narrow instance, and the shortcut limit run.
    run_model(1'b1, W'(27), 1'b0, 16'd0, "ovf8_seed27");
    run_model(1'b1, W'(27), 1'b1, 16'd0, "ovf8_seed27_sc");
    run_model(1'b0, W'(27), 1'b1, 16'd50, "limit50_sc");
    check("limit50_sc.len_le_50", 148'(len_a <= 16'd50), 148'd1);
    run_model(1'b0, '1, 1'b0, 16'd0, "ovf_all_ones");

    // Reset at cycle 30 of a seed-27 run.
    sel8 = 1'b0;
    start_a = 1'b1; seed_a = W'(27); sc_a = 1'b0; ms_a = '0;
    @(negedge clk);
    start_a = 1'b0;
    for (k = 0; k < 30; k++) @(negedge clk);
    check("abort.busy_before", 148'(busy_a), 148'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.busy",      148'(busy_a),   148'd0);
    check("abort.done",      148'(done_a),   148'd0);
    check("abort.status",    148'(status_a), 148'd0);
    check("abort.orbit_len", 148'(len_a),    148'd0);
    check("abort.record",    148'(rec_a),    148'd0);
    done_cnt = 0;
    for (k = 0; k < 150; k++) begin
      @(negedge clk);
      if (done_a) done_cnt++;
    end
    check("abort.no_done", 148'(done_cnt), 148'd0);
    run(1'b0, W'(6), 1'b0, 16'd0, 0, 8, W'(16), 9, 1'b0, "after_abort_seed6");

    // Randomized runs on both instances against the reference model.
    for (int i = 0; i < 14; i++) begin
      bits = (i % 2 == 0) ? $urandom_range(1, 20) : $urandom_range(120, 144);
      s    = {$urandom, $urandom, $urandom, $urandom, $urandom};
      mask = (W'(1) << bits) - W'(1);
      if (bits == W) mask = '1;
      s    = s & mask;
      run_model(1'b0, s, 1'($urandom), ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 300)) : 16'd0,
                $sformatf("rand_w%0d", i));
    end
    for (int i = 0; i < 14; i++) begin
      run_model(1'b1, W'($urandom_range(0, 255)), 1'($urandom),
                ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 40)) : 16'd0,
                $sformatf("rand_n%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/collatz_engine.md
# collatz_engine

Parametrised Collatz orbit engine: a successor to the fixed-width core with a start/busy/done handshake. Given a seed, it iterates n → n/2 or 3n+1 until n reaches 1 and reports orbit length, path record and a termination status. It adds an optional shortcut mode, (3n+1)/2 in one cycle, and a programmable step limit. It sits behind the byte-addressed TinyTapeout I/O wrapper, which loads `seed` and reads back results.

## Interface
- `WIDTH`, default 144: width of the iterate, seed and path record.
- `OLEN_BITS`, default 16: width of the orbit-length counter and the step limit.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  sampled only in IDLE; a 1 launches a run.
- `seed`  in  WIDTH  starting value, latched on an accepted `start`.
- `shortcut`  in  1  latched on `start`; 1 selects shortcut mode.
- `max_steps`  in  OLEN_BITS  latched on `start`; 0 means the limit is 2^OLEN_BITS−1.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a run terminates.
- `status`  out  2  termination code: 0 OK (reached 1), 1 OVF (overflow), 2 LIMIT (step limit), 3 ZERO (seed 0).
- `orbit_len`  out  OLEN_BITS  standard Collatz step count.
- `path_record`  out  WIDTH  maximum value reached, including the seed.

## Operation
- States: IDLE and RUN.
  - IDLE with `start`=1 → RUN. On that edge: iter←seed, orbit_len←0, path_record←seed, and `shortcut` and the limit are latched.
  - `start` during RUN is ignored. Changes on `seed`, `shortcut` or `max_steps` during RUN have no effect.
- Each RUN cycle evaluates the current iter, in this priority order:
  1. iter==0 → terminate with ZERO.
  2. iter==1 → terminate with OK.
  3. orbit_len+inc > limit → terminate with LIMIT. inc is 1 for an even iter or standard mode, 2 for an odd iter in shortcut mode.
  4. iter odd and 3·iter+1 ≥ 2^WIDTH → terminate with OVF. The value 3n+1 is computed in WIDTH+2 bits; the overflow test is identical in both modes.
  5. Otherwise take one step.
- Steps:
  - Even iter: iter←iter>>1, orbit_len+=1.
  - Odd iter, standard mode: iter←3n+1, orbit_len+=1.
  - Odd iter, shortcut mode: iter←(3n+1)>>1, orbit_len+=2.
- Path record: on every odd step, path_record←max(path_record, 3n+1). This applies in shortcut mode too, even though 3n+1 is never stored. Orbit_len and path_record are therefore identical in both modes for any OK run.
- Termination: the state returns to IDLE and `done` pulses. `status`, `orbit_len` and `path_record` then hold until the next accepted `start`.
  - On LIMIT or OVF, `orbit_len` and `path_record` hold their last valid values.
  - The iterate that failed is never committed.
- The orbit_len counter never wraps. The limit check in step 3 fires before any wrap could occur.

## Timing
- Reset, from any state including mid-run: state←IDLE. `busy`, `done` and `status` go to 0. `orbit_len`, `path_record` and the internal iter go to 0.
- Edge 0 samples `start`; `busy`=1 from edge 0.
- A run of S committed steps terminates at edge S+1.
  - After that edge: `busy`=0, `done`=1 for exactly one cycle, and the results are valid.
  - In shortcut mode, S counts cycles, not orbit_len.
- A new `start` may be asserted in the same cycle that `done` is high; it is accepted at the next edge.
- `reset` takes precedence over `start` on the same edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Seed 27, standard mode, max_steps=0:
  - `done` pulse after edge 112.
  - status=0, orbit_len=111, path_record=9232.
  - `busy` high for exactly 112 cycles.
- Seed 27, shortcut mode:
  - `done` after edge 71.
  - status=0, orbit_len=111, path_record=9232, matching the standard run.
- Seed 6, then seed 1, then seed 0, issued back-to-back by re-asserting `start` on each `done`:
  - seed 6: orbit_len=8, path_record=16, status=0.
  - seed 1: `done` after edge 1, orbit_len=0, path_record=1, status=0.
  - seed 0: `done` after edge 1, status=3, orbit_len=0.
- Overflow, with WIDTH=8:
  - Seed 255: `done` after edge 1, status=1, orbit_len=0, path_record=255.
  - Seed 27: status=1 at the first odd value whose 3n+1 exceeds 255.
    - The value 27 itself is fine: 82 fits in 8 bits.
    - Orbit_len and path_record must match a reference model run to that point.
- Step limit:
  - Seed 27, max_steps=50, standard mode: `done` after edge 51, status=2, orbit_len=50.
  - Same in shortcut mode: orbit_len ≤ 50, and it must match the reference model exactly.
- Reset during RUN:
  - Assert `reset` at cycle 30 of the seed-27 run.
  - Next cycle: busy=0, done=0, all outputs 0.
  - No `done` pulse ever follows for the aborted run.
  - A fresh seed-6 run then yields orbit_len=8.
